// File: rtl/lower_memory_responder.sv
// Lower-side memory responder: on-chip word array with fixed-latency access,
// lane-masked writes and power-up fill of every word.
module lower_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] LADDR,
  input  logic                  LRE,
  input  logic                  LWE,
  input  logic [DATA_WIDTH-1:0] LD,
  input  logic [MASK_WIDTH-1:0] LMASK,
  output logic [DATA_WIDTH-1:0] LQ,
  output logic                  LRDY,
  output logic                  LINIT_DONE
);

  localparam int LANE = DATA_WIDTH / MASK_WIDTH;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int LW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CW-1:0] INIT_END = CW'(DEPTH);
  localparam logic [LW-1:0] LAT_LOAD = LW'(LATENCY - 1);

  typedef enum logic [1:0] {INIT, IDLE, BUSY, RESP} state_t;

  state_t state, state_nx;

  logic [CW-1:0]         init_cnt;
  logic [LW-1:0]         lat_cnt;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_d;
  logic [MASK_WIDTH-1:0] a_mask;
  logic                  a_re;
  logic                  a_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  init_wr;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_d;
  logic [MASK_WIDTH-1:0] op_mask;
  logic                  op_re;
  logic                  op_we;
  logic [IW-1:0]         op_idx;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      INIT: if (init_cnt == INIT_END) state_nx = IDLE;
      IDLE, RESP: begin
        state_nx = IDLE;
        if (LRE | LWE) begin
          accept   = 1'b1;
          state_nx = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: if (lat_cnt == '0) state_nx = RESP;
      default: state_nx = INIT;
    endcase
  end

  // With unit latency RESP is entered straight from acceptance,
  // so the operation comes from the live inputs, not the latch.
  always_comb begin
    enter_resp = (state_nx == RESP);
    init_wr    = (state == INIT) && (init_cnt != INIT_END);
    op_addr    = (LATENCY == 1) ? LADDR : a_addr;
    op_d       = (LATENCY == 1) ? LD    : a_d;
    op_mask    = (LATENCY == 1) ? LMASK : a_mask;
    op_re      = (LATENCY == 1) ? LRE   : a_re;
    op_we      = (LATENCY == 1) ? LWE   : a_we;
    in_range   = {1'b0, op_addr} < DEPTH_X;
    op_idx     = op_addr[IW-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= INIT;
      init_cnt   <= '0;
      lat_cnt    <= '0;
      a_addr     <= '0;
      a_d        <= '0;
      a_mask     <= '0;
      a_re       <= 1'b0;
      a_we       <= 1'b0;
      LQ         <= '0;
      LINIT_DONE <= 1'b0;
    end else begin
      state <= state_nx;
      if (init_wr) init_cnt <= init_cnt + 1'b1;
      if (state == INIT && state_nx == IDLE) LINIT_DONE <= 1'b1;
      if (accept) begin
        a_addr  <= LADDR;
        a_d     <= LD;
        a_mask  <= LMASK;
        a_re    <= LRE;
        a_we    <= LWE;
        lat_cnt <= LAT_LOAD;
      end else if (state == BUSY && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (enter_resp && op_re) LQ <= in_range ? mem[op_idx] : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (init_wr) begin
      mem[init_cnt[IW-1:0]] <= INIT_VALUE;
    end else if (enter_resp && op_we && in_range) begin
      for (int i = 0; i < MASK_WIDTH; i++)
        if (op_mask[i])
          mem[op_idx][i*LANE +: LANE] <= op_d[i*LANE +: LANE];
    end
  end

  assign LRDY = (state == RESP);

endmodule

// File: tb/tb_lower_memory_responder.sv
// Bench for lower_memory_responder: directed requests with a scoreboard
// of expected LQ and LRDY cycle, checked by an independent monitor.
module tb_lower_memory_responder;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int MW    = 4;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam logic [DW-1:0] IV = 32'hA5A5A5A5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] LADDR = '0;
  logic          LRE = 1'b0;
  logic          LWE = 1'b0;
  logic [DW-1:0] LD = '0;
  logic [MW-1:0] LMASK = '0;
  logic [DW-1:0] LQ;
  logic          LRDY;
  logic          LINIT_DONE;

  lower_memory_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MASK_WIDTH(MW),
    .DEPTH(DEPTH),
    .LATENCY(LAT),
    .INIT_VALUE(IV)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .LADDR(LADDR),
    .LRE(LRE),
    .LWE(LWE),
    .LD(LD),
    .LMASK(LMASK),
    .LQ(LQ),
    .LRDY(LRDY),
    .LINIT_DONE(LINIT_DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    int            t;
    logic [DW-1:0] q;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (LRDY) begin
      if (sb.size() == 0) begin
        check("unexpected_lrdy", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("lrdy_cycle", cyc, e.t);
        check("lq", LQ, e.q);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called at a negedge where the DUT can accept; returns at the
  // negedge of the LRDY cycle so the next call lands back-to-back.
  task automatic req(logic re, logic we, logic [AW-1:0] a,
                     logic [DW-1:0] d, logic [MW-1:0] m,
                     logic [DW-1:0] q, int hold);
    exp_t e;
    LRE = re;
    LWE = we;
    LADDR = a;
    LD = d;
    LMASK = m;
    e.t = cyc + 1 + LAT;
    e.q = q;
    sb.push_back(e);
    repeat (hold) @(negedge CLK);
    LRE = 1'b0;
    LWE = 1'b0;
    repeat (LAT + 1 - hold) @(negedge CLK);
  endtask

  // Release at a negedge; the next posedge is the first init write,
  // and LINIT_DONE is expected DEPTH cycles after that edge.
  task automatic release_and_wait();
    int n;
    n = 0;
    RST = 1'b1;
    while (!LINIT_DONE && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("init_cycles", n, DEPTH + 1);
  endtask

  initial begin
    #1 RST = 1'b0;
    idle(2);
    check("rst_lq", LQ, 32'h0);
    check("rst_lrdy", {31'b0, LRDY}, 32'h0);
    check("rst_done", {31'b0, LINIT_DONE}, 32'h0);
    release_and_wait();

    req(1, 0, 5'd7, 32'h0, 4'hF, IV, 1);
    req(0, 1, 5'd5, 32'h12345678, 4'hF, IV, 1);
    req(1, 0, 5'd5, 32'h0, 4'hF, 32'h12345678, 1);
    idle(2);
    check("lq_hold", LQ, 32'h12345678);

    req(0, 1, 5'd2, 32'h0, 4'hF, 32'h12345678, 1);
    req(0, 1, 5'd2, 32'hDEADBEEF, 4'b0101, 32'h12345678, 1);
    req(1, 0, 5'd2, 32'h0, 4'hF, 32'h00AD00EF, 1);

    req(0, 1, 5'd3, 32'h11, 4'hF, 32'h00AD00EF, 1);
    req(1, 1, 5'd3, 32'h22, 4'hF, 32'h11, 1);
    req(1, 0, 5'd3, 32'h0, 4'hF, 32'h22, 1);

    req(0, 1, 5'd20, 32'hFFFFFFFF, 4'hF, 32'h22, 1);
    req(1, 0, 5'd20, 32'h0, 4'hF, 32'h0, 1);
    req(1, 0, 5'd4, 32'h0, 4'hF, IV, 1);

    req(1, 0, 5'd5, 32'h0, 4'h0, 32'h12345678, 1);
    idle(1);
    req(1, 0, 5'd5, 32'h0, 4'hF, 32'h12345678, 2);
    idle(2);

    LWE = 1'b1;
    LADDR = 5'd6;
    LD = 32'h66666666;
    LMASK = 4'hF;
    @(negedge CLK);
    LWE = 1'b0;
    #2 RST = 1'b0;
    #1;
    check("midrst_lq", LQ, 32'h0);
    check("midrst_done", {31'b0, LINIT_DONE}, 32'h0);
    check("midrst_lrdy", {31'b0, LRDY}, 32'h0);
    @(negedge CLK);
    idle(LAT + 1);
    release_and_wait();

    req(1, 0, 5'd6, 32'h0, 4'hF, IV, 1);
    req(1, 0, 5'd5, 32'h0, 4'hF, IV, 1);
    idle(LAT + 2);
    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
